// File: rtl/config_pkg.sv
// CONFIG: system-wide configuration constants.
//   BYTE_WIDTH : width of a byte on the serial transmit path
package CONFIG;

    localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/midi_pkg.sv
// MIDI: shared MIDI protocol types.
//   message_type_t : 4-bit status-nibble codes for channel voice messages
//   message_t      : one channel message (type + two data bytes)
//   DATA_WIDTH     : width of a data byte field inside message_t
package MIDI;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        NOTE_OFF         = 4'h8,
        NOTE_ON          = 4'h9,
        POLY_PRESSURE    = 4'hA,
        CONTROL_CHANGE   = 4'hB,
        PROGRAM_CHANGE   = 4'hC,
        CHANNEL_PRESSURE = 4'hD,
        PITCH_BEND       = 4'hE,
        SYSTEM           = 4'hF
    } message_type_t;

    typedef struct packed {
        message_type_t         message_type;
        logic [DATA_WIDTH-1:0] data_byte1;
        logic [DATA_WIDTH-1:0] data_byte2;
    } message_t;

endpackage

// File: rtl/midi_encoder_if.sv
// midi_encoder_if: bundle of the encoder's message-side and byte-side
// handshakes.
//   message / message_valid / message_ready : message request channel
//   data_out / data_out_valid / data_out_ready : byte stream to the UART
//   message_dropped : pulse for an accepted but unsupported message
// master = message producer / byte consumer, slave = the encoder.
interface midi_encoder_if;
    import MIDI::*;
    import CONFIG::*;

    message_t              message;
    logic                  message_valid;
    logic                  message_ready;
    logic [BYTE_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_ready;
    logic                  message_dropped;

    modport master (
        output message, message_valid, data_out_ready,
        input  message_ready, data_out, data_out_valid, message_dropped
    );

    modport slave (
        input  message, message_valid, data_out_ready,
        output message_ready, data_out, data_out_valid, message_dropped
    );

endinterface

// File: rtl/midi_encoder.sv
// midi_encoder: turns MIDI channel messages into a byte stream for a UART.
//   clock_50_000_000 : system clock, rising edge
//   reset_l          : asynchronous active-low reset
//   message, message_valid, message_ready : message input handshake
//   data_out, data_out_valid, data_out_ready : byte output handshake
//   message_dropped  : one-cycle pulse after accepting an unsupported type
// Running status: when enabled, the status byte is omitted if it matches the
// last status byte sent and the line has not been idle for RS_TIMEOUT cycles.
module midi_encoder
    import MIDI::*;
    import CONFIG::*;
#(
    parameter logic [3:0]  CHANNEL        = 4'd0,
    parameter bit          RUNNING_STATUS = 1'b1,
    parameter int unsigned RS_TIMEOUT     = 50_000_000
) (
    input  logic                  clock_50_000_000,
    input  logic                  reset_l,
    input  message_t              message,
    input  logic                  message_valid,
    output logic                  message_ready,
    output logic [BYTE_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  message_dropped
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] SEND_STATUS = 2'd1;
    localparam logic [1:0] SEND_DATA1  = 2'd2;
    localparam logic [1:0] SEND_DATA2  = 2'd3;

    localparam int             CNT_W   = (RS_TIMEOUT < 1) ? 1 : $clog2(RS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RS_TIMEOUT);

    function automatic logic [BYTE_WIDTH-1:0] status_byte(input message_type_t t);
        return BYTE_WIDTH'({t, CHANNEL});
    endfunction

    // MIDI data bytes always have bit 7 clear.
    function automatic logic [BYTE_WIDTH-1:0] data_byte(input logic [DATA_WIDTH-1:0] d);
        return BYTE_WIDTH'({1'b0, d[6:0]});
    endfunction

    function automatic logic is_supported(input message_type_t t);
        return (t == NOTE_OFF) || (t == NOTE_ON) ||
               (t == CONTROL_CHANGE) || (t == PROGRAM_CHANGE);
    endfunction

    logic [1:0]            state_q, state_d;
    message_t              buf_q, buf_d;
    logic [BYTE_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_out_valid_q, data_out_valid_d;
    logic                  dropped_q, dropped_d;
    logic [BYTE_WIDTH-1:0] last_status_q, last_status_d;
    logic                  last_valid_q, last_valid_d;
    logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;

    logic accept;
    logic byte_hs;
    logic rs_hit;

    assign message_ready = (state_q == IDLE) && reset_l;
    assign accept        = message_valid && message_ready;
    assign byte_hs       = data_out_valid_q && data_out_ready;
    assign rs_hit        = RUNNING_STATUS && last_valid_q &&
                           (status_byte(message.message_type) == last_status_q);

    always_comb begin
        state_d          = state_q;
        buf_d            = buf_q;
        data_out_d       = data_out_q;
        data_out_valid_d = data_out_valid_q;
        dropped_d        = 1'b0;
        last_status_d    = last_status_q;
        last_valid_d     = last_valid_q;

        // Idle counter: any cycle without a byte handshake counts as idle.
        if (byte_hs)                  idle_cnt_d = '0;
        else if (idle_cnt_q == CNT_MAX) idle_cnt_d = idle_cnt_q;
        else                          idle_cnt_d = idle_cnt_q + 1'b1;

        // The receiver may have lost running status after a long silence.
        if (!byte_hs && (idle_cnt_d == CNT_MAX)) last_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d = message;
                    if (is_supported(message.message_type)) begin
                        data_out_valid_d = 1'b1;
                        if (rs_hit) begin
                            state_d    = SEND_DATA1;
                            data_out_d = data_byte(message.data_byte1);
                        end else begin
                            state_d    = SEND_STATUS;
                            data_out_d = status_byte(message.message_type);
                        end
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
            end
            SEND_STATUS: begin
                if (byte_hs) begin
                    last_status_d = status_byte(buf_q.message_type);
                    last_valid_d  = 1'b1;
                    state_d       = SEND_DATA1;
                    data_out_d    = data_byte(buf_q.data_byte1);
                end
            end
            SEND_DATA1: begin
                if (byte_hs) begin
                    if (buf_q.message_type == PROGRAM_CHANGE) begin
                        state_d          = IDLE;
                        data_out_valid_d = 1'b0;
                    end else begin
                        state_d    = SEND_DATA2;
                        data_out_d = data_byte(buf_q.data_byte2);
                    end
                end
            end
            SEND_DATA2: begin
                if (byte_hs) begin
                    state_d          = IDLE;
                    data_out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d          = IDLE;
                data_out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state_q          <= IDLE;
            buf_q            <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            dropped_q        <= 1'b0;
            last_status_q    <= '0;
            last_valid_q     <= 1'b0;
            idle_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            buf_q            <= buf_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            dropped_q        <= dropped_d;
            last_status_q    <= last_status_d;
            last_valid_q     <= last_valid_d;
            idle_cnt_q       <= idle_cnt_d;
        end
    end

    assign data_out        = data_out_q;
    assign data_out_valid  = data_out_valid_q;
    assign message_dropped = dropped_q;

    // Bit 7 of the buffered data bytes is never transmitted.
    logic unused_bits;
    assign unused_bits = ^{buf_q.data_byte1[DATA_WIDTH-1:7], buf_q.data_byte2[DATA_WIDTH-1:7]};

endmodule
